// File: rtl/pe_mult_pipe.sv
// pe_mult_pipe: pipelined signed multiplier array for the matrix PE.
//
// LANES independent lanes multiply packed neuron/weight operands element-wise
// and present exact 2*DW-bit products to the accumulate stage. Two registered
// stages (S1 operands, S2 products) sit behind a valid/ready handshake. Either
// stage advances whenever the stage after it can take its beat, so the
// pipeline holds at most two beats and never reorders them.
//
// Build option:
//   PE_MULT_INT8_EN  when defined, in_prec travels with each beat. prec = 1
//                    splits every lane into two signed DW/2-bit halves and
//                    produces two DW-bit products per lane. When undefined,
//                    in_prec is ignored and every beat uses the full-width
//                    product. The port list is the same in both builds.
module pe_mult_pipe #(
  parameter int LANES = 32,
  parameter int DW    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_prec,
  input  logic [LANES*DW-1:0]     mult_neuron,
  input  logic [LANES*DW-1:0]     mult_weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*2*DW-1:0]   mult_result
);

  localparam int HW = DW / 2;   // half-lane operand width in dual mode
  localparam int RW = 2 * DW;   // lane result width

  // --------------------------------------------------------------------------
  // Pipeline state
  // --------------------------------------------------------------------------
  logic                  s1_valid;
  logic [LANES*DW-1:0]   s1_neuron;
  logic [LANES*DW-1:0]   s1_weight;
  logic                  s2_valid;
  logic [LANES*RW-1:0]   s2_result;

  // Products computed combinationally from the S1 operands.
  logic [LANES*RW-1:0]   s1_product;

  // Handshake and advance controls.
  logic                  s2_take;   // S2 can accept a beat this cycle
  logic                  s1_take;   // S1 can accept a beat this cycle
  logic                  in_fire;   // input handshake
  logic                  s1_move;   // S1 beat moves into S2

  // Per-beat precision flag, kept only when dual mode is built.
  logic                  s1_prec;

  // --------------------------------------------------------------------------
  // Advance logic
  // --------------------------------------------------------------------------
  // S2 frees up when empty or when downstream takes its beat; S1 frees up when
  // empty or when its beat is moving on. in_ready is therefore a combinational
  // function of out_ready and the two valids, and is 1 throughout reset.
  assign s2_take  = !s2_valid || out_ready;
  assign s1_take  = !s1_valid || (s1_valid && s2_take);
  assign in_ready = s1_take;
  assign in_fire  = in_valid && s1_take;
  assign s1_move  = s1_valid && s2_take;

  // --------------------------------------------------------------------------
  // Stage S1: operand register
  // --------------------------------------------------------------------------
  // Capture operands on the input handshake; the valid bit follows in_valid
  // whenever S1 is free to take a beat, so a beat moving on without a
  // replacement empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register in
    // the design samples pre-edge values, independent of block ordering.
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_take) begin
      s1_valid <= in_valid;
    end
  end

  // Operand data loads only on a handshake, so idle input data never leaks in.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the wide data registers are reset too, because the reset state of
    // S1 and of the output word is visible and must read as zero.
    if (!rst_n) begin
      s1_neuron <= '0;
      s1_weight <= '0;
    end else if (in_fire) begin
      s1_neuron <= mult_neuron;
      s1_weight <= mult_weight;
    end
  end

`ifdef PE_MULT_INT8_EN
  // Precision flag rides with its beat so mixed-mode traffic is legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_prec <= 1'b0;
    end else if (in_fire) begin
      s1_prec <= in_prec;
    end
  end
`else
  // Single-precision build: no flag register, every beat is full width.
  logic unused_in_prec;
  assign unused_in_prec = in_prec;
  assign s1_prec        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Lane multipliers
  // --------------------------------------------------------------------------
  for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
    logic [DW-1:0]        op_n;
    logic [DW-1:0]        op_w;
    logic signed [RW-1:0] full_n;
    logic signed [RW-1:0] full_w;
    logic signed [RW-1:0] full_p;
    logic signed [DW-1:0] lo_n;
    logic signed [DW-1:0] lo_w;
    logic signed [DW-1:0] hi_n;
    logic signed [DW-1:0] hi_w;
    logic signed [DW-1:0] lo_p;
    logic signed [DW-1:0] hi_p;

    assign op_n = s1_neuron[lane*DW +: DW];
    assign op_w = s1_weight[lane*DW +: DW];

    // Full-width product: operands are sign-extended to the result width
    // first, so the multiply is exact with no truncation.
    assign full_n = $signed({{DW{op_n[DW-1]}}, op_n});
    assign full_w = $signed({{DW{op_w[DW-1]}}, op_w});
    assign full_p = full_n * full_w;

    // Dual mode: each signed half-width pair gives an exact DW-bit product,
    // which is already the sign-extended form the accumulator expects.
    assign lo_n = $signed({{HW{op_n[HW-1]}}, op_n[HW-1:0]});
    assign lo_w = $signed({{HW{op_w[HW-1]}}, op_w[HW-1:0]});
    assign hi_n = $signed({{HW{op_n[DW-1]}}, op_n[DW-1:HW]});
    assign hi_w = $signed({{HW{op_w[DW-1]}}, op_w[DW-1:HW]});
    assign lo_p = lo_n * lo_w;
    assign hi_p = hi_n * hi_w;

    // Select the lane result layout for the beat's precision.
    always_comb begin
      // NOTE: the output gets a default before the branch so every path
      // assigns it and no latch can be inferred.
      s1_product[lane*RW +: RW] = full_p;
      if (s1_prec) begin
        s1_product[lane*RW +: RW] = {hi_p, lo_p};
      end
    end
  end : g_lane

  // --------------------------------------------------------------------------
  // Stage S2: output register
  // --------------------------------------------------------------------------
  // Load the next product set when S1 hands over; otherwise drop the beat once
  // downstream accepts it; otherwise hold value and valid stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (s1_move) begin
      s2_valid <= 1'b1;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Product data changes only when a new beat arrives from S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_result <= '0;
    end else if (s1_move) begin
      s2_result <= s1_product;
    end
  end

  assign out_valid   = s2_valid;
  assign mult_result = s2_result;

endmodule : pe_mult_pipe

// File: tb/tb_pe_mult_pipe.sv
// Testbench for pe_mult_pipe: directed and random traffic with a scoreboard
// of expected product words pushed on input handshakes and popped on output
// handshakes. Dual-mode steps run only when PE_MULT_INT8_EN is defined.
module tb_pe_mult_pipe;

  localparam int LANES = 32;
  localparam int DW    = 16;
  localparam int HW    = DW / 2;
  localparam int RW    = 2 * DW;
  localparam int IW    = LANES * DW;
  localparam int OW    = LANES * RW;
`ifdef PE_MULT_INT8_EN
  localparam bit INT8 = 1'b1;
`else
  localparam bit INT8 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_prec;
  logic [IW-1:0] mult_neuron;
  logic [IW-1:0] mult_weight;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] mult_result;

  pe_mult_pipe #(.LANES(LANES), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_prec     (in_prec),
    .mult_neuron (mult_neuron),
    .mult_weight (mult_weight),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .mult_result (mult_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;
  logic [OW-1:0] sb[$];
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_result;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    int bad;
    checks++;
    assert (obs === exp) else begin
      errors++;
      bad = 0;
      for (int i = LANES - 1; i >= 0; i--)
        if (obs[i*RW +: RW] !== exp[i*RW +: RW]) bad = i;
      $error("FAIL %s lane %0d observed=%h expected=%h", tag, bad,
             obs[bad*RW +: RW], exp[bad*RW +: RW]);
    end
  endtask

  // Reference products, computed lane by lane with integer arithmetic.
  function automatic logic [OW-1:0] model(input logic [IW-1:0] n, input logic [IW-1:0] w,
                                          input logic p);
    logic [OW-1:0] r;
    longint a, b, prod;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (INT8 && p) begin
        a = longint'($signed(n[i*DW +: HW]));
        b = longint'($signed(w[i*DW +: HW]));
        prod = a * b;
        r[i*RW +: DW] = prod[DW-1:0];
        a = longint'($signed(n[i*DW + HW +: HW]));
        b = longint'($signed(w[i*DW + HW +: HW]));
        prod = a * b;
        r[i*RW + DW +: DW] = prod[DW-1:0];
      end else begin
        a = longint'($signed(n[i*DW +: DW]));
        b = longint'($signed(w[i*DW +: DW]));
        prod = a * b;
        r[i*RW +: RW] = prod[RW-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] rand_vec();
    logic [IW-1:0] v;
    for (int k = 0; k < IW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle: observe handshakes at the falling edge, then step past
  // the rising edge so the caller can drive the next inputs.
  task automatic tick();
    @(negedge clk);
    if (prev_stall) begin
      check("stall_valid_hold", OW'(out_valid), OW'(1'b1));
      check("stall_data_hold", mult_result, prev_result);
    end
    prev_stall  = out_valid && !out_ready;
    prev_result = mult_result;
    if (out_valid && out_ready) begin
      n_out++;
      check("beat_expected", OW'(sb.size() != 0), OW'(1'b1));
      if (sb.size() != 0) check("result", mult_result, sb.pop_front());
    end
    if (in_valid && in_ready) begin
      n_in++;
      sb.push_back(model(mult_neuron, mult_weight, in_prec));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("drain_empty", OW'(sb.size()), OW'(0));
  endtask

  initial begin
    logic [OW-1:0] exp_w;
    logic [IW-1:0] n_v, w_v;
    int acc, outs;

    rst_n = 1'b0; in_valid = 1'b0; in_prec = 1'b0; out_ready = 1'b1;
    mult_neuron = '0; mult_weight = '0;
    #2;
    // Reset state
    check("rst_out_valid", OW'(out_valid), OW'(1'b0));
    check("rst_result", mult_result, '0);
    check("rst_in_ready", OW'(in_ready), OW'(1'b1));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", OW'(in_ready), OW'(1'b1));

    // Single beat: lane0 3 x -5, lane31 -32768 x -32768
    n_v = '0; w_v = '0;
    n_v[0 +: DW] = 16'sd3;       w_v[0 +: DW] = -16'sd5;
    n_v[31*DW +: DW] = 16'h8000; w_v[31*DW +: DW] = 16'h8000;
    mult_neuron = n_v; mult_weight = w_v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_not_early", OW'(out_valid), OW'(1'b0));
    tick();
    check("lat_valid", OW'(out_valid), OW'(1'b1));
    check("lane0", OW'(mult_result[0 +: RW]), OW'(32'hFFFF_FFF1));
    check("lane31", OW'(mult_result[31*RW +: RW]), OW'(32'h4000_0000));
    tick();
    check("single_pulse", OW'(out_valid), OW'(1'b0));

    // 100 back-to-back random beats at full rate
    outs = n_out;
    for (int i = 0; i < 100; i++) begin
      mult_neuron = rand_vec(); mult_weight = rand_vec(); in_valid = 1'b1;
      in_prec = 1'($urandom);
      #1;
      check("b2b_in_ready", OW'(in_ready), OW'(1'b1));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("b2b_count", OW'(n_out - outs), OW'(100));
    check("b2b_empty", OW'(sb.size()), OW'(0));

    // Backpressure: three beats offered, output stalled for 5 cycles
    out_ready = 1'b0;
    outs = n_out;
    acc = n_in;
    for (int i = 0; i < 5; i++) begin
      if (n_in - acc < 3) begin
        mult_neuron = rand_vec(); mult_weight = rand_vec(); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    check("bp_accepted_two", OW'(n_in - acc), OW'(2));
    check("bp_in_ready_low", OW'(in_ready), OW'(1'b0));
    check("bp_out_valid", OW'(out_valid), OW'(1'b1));
    out_ready = 1'b1;
    for (int i = 0; i < 10 && n_in - acc < 3; i++) tick();
    in_valid = 1'b0;
    drain();
    check("bp_out_count", OW'(n_out - outs), OW'(3));

`ifdef PE_MULT_INT8_EN
    // Dual mode followed by a normal-mode beat with the same operands
    for (int i = 0; i < LANES; i++) begin
      n_v[i*DW +: DW] = 16'h7F80;
      w_v[i*DW +: DW] = 16'h80FF;
    end
    for (int i = 0; i < LANES; i++) exp_w[i*RW +: RW] = 32'hC080_0080;
    mult_neuron = n_v; mult_weight = w_v; in_prec = 1'b1; in_valid = 1'b1;
    tick();
    in_prec = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    check("int8_result", mult_result, exp_w);
    drain();
`endif

    // Reset with two beats in flight
    out_ready = 1'b0;
    mult_neuron = rand_vec(); mult_weight = rand_vec(); in_valid = 1'b1;
    tick();
    mult_neuron = rand_vec(); mult_weight = rand_vec();
    tick();
    in_valid = 1'b0;
    check("pre_rst_full", OW'(sb.size()), OW'(2));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", OW'(out_valid), OW'(1'b0));
    check("async_rst_result", mult_result, '0);
    sb.delete();
    prev_stall = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("discarded_stay_gone", OW'(out_valid), OW'(1'b0));
    end

    // Random in_valid/out_ready traffic
    acc = n_in;
    outs = n_out;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom_range(0, 2) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      in_prec = 1'($urandom);
      mult_neuron = rand_vec(); mult_weight = rand_vec();
      tick();
    end
    drain();
    check("rand_once_each", OW'(n_out - outs), OW'(n_in - acc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_pe_mult_pipe
